acquisition_sequencer: RTL and testbench

Run-level controller for the pulse-echo averaging chain. It fires the transmitter trigger at a fixed period and gates exactly one frame of ADC samples into the averager after each trigger. It counts triggers up to the averaging depth, then opens the averager's result stream to the downstream FIR and reports completion. It sits between the ADC/pulser front end and the averager, and it owns the averager's framing and clear.

---
 rtl/acquisition_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_acquisition_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/acquisition_sequencer.sv
// Run-level controller: fires the pulser trigger, gates one ADC frame per trigger into the averager,
// then opens the averager result stream. Optional macro ACQ_SEQ_READOUT_TIMEOUT_EN adds a READOUT watchdog.
module acquisition_sequencer #(
    parameter int SAMPLES_PER_TRIGGER = 1024,
    parameter int AVERAGES            = 128,
    parameter int TRIGGER_PERIOD      = 4096,
    parameter int COUNT_WIDTH         = 16
) (
    input  logic                   s00_axis_aclk,
    input  logic                   s00_axis_areset,
    input  logic                   start_in,
    input  logic                   abort_in,
    input  logic                   adc_tvalid_in,
    input  logic [31:0]            adc_tdata_in,
    output logic                   trigger_out,
    output logic                   avg_tvalid_out,
    output logic [31:0]            avg_tdata_out,
    output logic                   avg_tlast_out,
    output logic                   avg_clear_out,
    input  logic                   res_tvalid_in,
    input  logic                   res_tlast_in,
    input  logic                   fir_tready_in,
    output logic                   res_tready_out,
    output logic                   busy_out,
    output logic                   done_out,
    output logic                   error_out,
    output logic [COUNT_WIDTH-1:0] trigger_count_out,
    output logic [2:0]             dbg_state_o
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FIRE    = 3'd1,
        CAPTURE = 3'd2,
        HOLDOFF = 3'd3,
        READOUT = 3'd4,
        DONE    = 3'd5
    } state_t;

    localparam logic [COUNT_WIDTH-1:0] ONE         = COUNT_WIDTH'(1);
    localparam logic [COUNT_WIDTH-1:0] AVG_LAST    = COUNT_WIDTH'(AVERAGES);
    localparam logic [COUNT_WIDTH-1:0] SAMPLE_LAST = COUNT_WIDTH'(SAMPLES_PER_TRIGGER - 1);
    localparam logic [COUNT_WIDTH-1:0] PERIOD_LAST = COUNT_WIDTH'(TRIGGER_PERIOD - 1);

    state_t                 state_q, state_d;
    logic [COUNT_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
    logic [COUNT_WIDTH-1:0] samp_cnt_q, samp_cnt_d;
    logic [COUNT_WIDTH-1:0] period_cnt_q, period_cnt_d;
    logic                   avg_tvalid_q, avg_tvalid_d;
    logic [31:0]            avg_tdata_q, avg_tdata_d;
    logic                   avg_tlast_q, avg_tlast_d;
    logic                   clear_q, clear_d;
    logic                   error_q, error_d;
    logic                   period_end;
    logic                   frame_end;
    logic                   res_beat;
    logic                   res_last;
    logic                   timeout;

    // Handshake on the result stream: valid && ready; the run completes on the tlast beat.
    assign res_tready_out = (state_q == READOUT) && fir_tready_in;
    assign res_beat       = res_tvalid_in && res_tready_out;
    assign res_last       = res_beat && res_tlast_in;
    assign period_end     = (period_cnt_q == PERIOD_LAST);
    assign frame_end      = (state_q == CAPTURE) && adc_tvalid_in && (samp_cnt_q == SAMPLE_LAST);

`ifdef ACQ_SEQ_READOUT_TIMEOUT_EN
    logic [15:0] wd_q, wd_d;

    always_comb begin
        wd_d = 16'd0;
        if (state_q == READOUT && !res_beat) begin
            wd_d = wd_q + 16'd1;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            wd_q <= 16'd0;
        end else begin
            wd_q <= wd_d;
        end
    end

    assign timeout = (state_q == READOUT) && (wd_q == 16'hFFFF) && !res_beat;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d      = state_q;
        trig_cnt_d   = trig_cnt_q;
        samp_cnt_d   = samp_cnt_q;
        period_cnt_d = period_end ? period_cnt_q : period_cnt_q + ONE;
        avg_tvalid_d = 1'b0;
        avg_tdata_d  = avg_tdata_q;
        avg_tlast_d  = 1'b0;
        clear_d      = 1'b0;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (start_in && !abort_in) begin
                    state_d    = FIRE;
                    clear_d    = 1'b1;
                    trig_cnt_d = '0;
                    error_d    = 1'b0;
                end
            end
            FIRE: begin
                state_d    = CAPTURE;
                trig_cnt_d = trig_cnt_q + ONE;
                samp_cnt_d = '0;
            end
            CAPTURE: begin
                if (period_end) begin
                    error_d = 1'b1;
                end
                if (adc_tvalid_in) begin
                    avg_tvalid_d = 1'b1;
                    avg_tdata_d  = adc_tdata_in;
                    avg_tlast_d  = (samp_cnt_q == SAMPLE_LAST);
                    samp_cnt_d   = samp_cnt_q + ONE;
                end
                // An overrun frame goes straight to the next trigger.
                if (frame_end) begin
                    if (trig_cnt_q == AVG_LAST) begin
                        state_d = READOUT;
                    end else if (period_end) begin
                        state_d = FIRE;
                    end else begin
                        state_d = HOLDOFF;
                    end
                end
            end
            HOLDOFF: begin
                if (period_end) begin
                    state_d = FIRE;
                end
            end
            READOUT: begin
                if (res_last) begin
                    state_d = DONE;
                end else if (timeout) begin
                    state_d = IDLE;
                    error_d = 1'b1;
                    clear_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort_in && state_q != IDLE) begin
            state_d      = IDLE;
            clear_d      = 1'b1;
            avg_tvalid_d = 1'b0;
            avg_tlast_d  = 1'b0;
        end

        // The period counter reads 0 during FIRE so consecutive triggers are exactly one period apart.
        if (state_d == FIRE || state_d == IDLE) begin
            period_cnt_d = '0;
        end
    end

    always_ff @(posedge s00_axis_aclk or posedge s00_axis_areset) begin
        if (s00_axis_areset) begin
            state_q      <= IDLE;
            trig_cnt_q   <= '0;
            samp_cnt_q   <= '0;
            period_cnt_q <= '0;
            avg_tvalid_q <= 1'b0;
            avg_tdata_q  <= 32'd0;
            avg_tlast_q  <= 1'b0;
            clear_q      <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_cnt_q   <= trig_cnt_d;
            samp_cnt_q   <= samp_cnt_d;
            period_cnt_q <= period_cnt_d;
            avg_tvalid_q <= avg_tvalid_d;
            avg_tdata_q  <= avg_tdata_d;
            avg_tlast_q  <= avg_tlast_d;
            clear_q      <= clear_d;
            error_q      <= error_d;
        end
    end

    assign trigger_out       = (state_q == FIRE);
    assign busy_out          = (state_q != IDLE);
    assign done_out          = (state_q == DONE);
    assign avg_tvalid_out    = avg_tvalid_q;
    assign avg_tdata_out     = avg_tdata_q;
    assign avg_tlast_out     = avg_tlast_q;
    assign avg_clear_out     = clear_q;
    assign error_out         = error_q;
    assign trigger_count_out = trig_cnt_q;
    assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_acquisition_sequencer.sv
// Randomized bench for acquisition_sequencer: a timeline model (trigger times, sample cycles,
// readout window) predicts every output cycle by cycle.
`timescale 1ns/1ps
module tb_acquisition_sequencer;

    localparam int S    = 8;
    localparam int A    = 4;
    localparam int P    = 20;
    localparam int CW   = 16;
    localparam int MAXC = 512;
    localparam int BIG  = 1 << 30;
`ifdef ACQ_SEQ_READOUT_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          start, abort, adc_tvalid;
    logic [31:0]   adc_tdata;
    logic          trigger, avg_tvalid, avg_tlast, avg_clear;
    logic [31:0]   avg_tdata;
    logic          res_tvalid, res_tlast, fir_tready, res_tready;
    logic          busy, done, error;
    logic [CW-1:0] tcount;
    logic [2:0]    dbg_state;

    acquisition_sequencer #(
        .SAMPLES_PER_TRIGGER(S), .AVERAGES(A), .TRIGGER_PERIOD(P), .COUNT_WIDTH(CW)
    ) dut (
        .s00_axis_aclk(clk), .s00_axis_areset(rst),
        .start_in(start), .abort_in(abort),
        .adc_tvalid_in(adc_tvalid), .adc_tdata_in(adc_tdata),
        .trigger_out(trigger),
        .avg_tvalid_out(avg_tvalid), .avg_tdata_out(avg_tdata), .avg_tlast_out(avg_tlast),
        .avg_clear_out(avg_clear),
        .res_tvalid_in(res_tvalid), .res_tlast_in(res_tlast), .fir_tready_in(fir_tready),
        .res_tready_out(res_tready),
        .busy_out(busy), .done_out(done), .error_out(error),
        .trigger_count_out(tcount), .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cur_c    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s @cycle %0d: got %0h, expected %0h", tag, cur_c, got, exp);
    endtask

    // Stimulus plan and expectations for one run, indexed by cycle relative to the start pulse.
    logic        v_arr [MAXC];
    logic [31:0] d_arr [MAXC];
    int          samp_c [A*S];
    int          trig_t [A];
    int          ovr_t [A];
    logic [32:0] exp_q [$];
    int          exp_cyc_q [$];
    bit          last_err = 1'b0;
    int          last_cnt = 0;

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; adc_tvalid = 1'b0; adc_tdata = 32'd0;
        res_tvalid = 1'b0; res_tlast = 1'b0; fir_tready = 1'b0;
    endtask

    task automatic do_run(input int mode, input int ab_frame, input int ab_samp, input bit no_hs);
        int  t, l, r, ab, err_cyc, end_c, done_c, clr2_c, n_trig, limit, cnt, k, cc, acq_end;
        bit  rd, hs_now, hs_seen, exp_trig;

        for (int c = 0; c < MAXC; c++) begin
            case (mode)
                0:       v_arr[c] = 1'b1;
                1:       v_arr[c] = (c % 2 == 0);
                2:       v_arr[c] = (c % 3 == 0);
                default: v_arr[c] = ($urandom_range(0, 2) != 0);
            endcase
            if (c >= MAXC - 64) v_arr[c] = 1'b1;
            d_arr[c] = $urandom;
        end

        // Timeline: frame f fires at t, takes the first S valid cycles after t; an overrun
        // (still capturing at t+P-1) flags error and fires right after the last sample.
        t = 1; r = -1;
        for (int f = 0; f < A; f++) begin
            trig_t[f] = t;
            k = 0; cc = t + 1;
            while (k < S && cc < MAXC) begin
                if (v_arr[cc]) begin samp_c[f*S+k] = cc; k++; end
                cc++;
            end
            l = samp_c[f*S+S-1];
            ovr_t[f] = (l >= t + P - 1) ? t + P - 1 : BIG;
            if (f < A - 1) t = (ovr_t[f] != BIG) ? l + 1 : t + P;
            else r = l + 1;
        end

        ab = (ab_frame >= 0) ? samp_c[ab_frame*S + ab_samp - 1] + 1 : BIG;
        n_trig = 0; err_cyc = BIG;
        for (int f = 0; f < A; f++) begin
            if (trig_t[f] <= ab) n_trig++;
            if (ovr_t[f] <= ab && ovr_t[f] + 1 < err_cyc) err_cyc = ovr_t[f] + 1;
        end
        exp_q.delete(); exp_cyc_q.delete();
        for (int i = 0; i < A*S; i++) begin
            if (samp_c[i] < ab) begin
                exp_q.push_back({(i % S == S - 1), d_arr[samp_c[i]]});
                exp_cyc_q.push_back(samp_c[i] + 1);
            end
        end

        end_c = BIG; done_c = BIG; clr2_c = BIG;
        if (ab != BIG) begin end_c = ab; clr2_c = ab + 1; end
        acq_end = (ab < r) ? ab : r;
        hs_seen = 1'b0;
        limit = no_hs ? r + 65600 : MAXC + 300;

        for (int c = 0; c <= limit && c <= end_c + 2; c++) begin
            cur_c = c;
            start = (c == 0) || (c >= 2 && c < acq_end && $urandom_range(0, 15) == 0);
            abort = (c == ab);
            adc_tvalid = (c < MAXC) ? v_arr[c] : 1'($urandom_range(0, 1));
            adc_tdata  = (c < MAXC) ? d_arr[c] : $urandom;
            fir_tready = 1'($urandom_range(0, 1));
            res_tvalid = (no_hs && c >= r) ? 1'b0 : 1'($urandom_range(0, 1));
            res_tlast  = ($urandom_range(0, 3) == 0);
            if (!no_hs && c >= r + 100) begin
                fir_tready = 1'b1; res_tvalid = 1'b1; res_tlast = 1'b1;
            end
            rd = (c >= r) && (c <= ab) && !hs_seen && (!TO_EN || c <= r + 65535);

            @(negedge clk);
            hs_now = rd && res_tvalid && fir_tready && res_tlast && (c < ab);
            exp_trig = 1'b0; cnt = 0;
            for (int f = 0; f < A; f++) begin
                if (trig_t[f] <= ab) begin
                    if (trig_t[f] == c) exp_trig = 1'b1;
                    if (trig_t[f] + 1 <= c) cnt++;
                end
            end
            check("trigger", trigger, exp_trig);
            check("busy", busy, (c >= 1 && c <= end_c));
            check("done", done, (c == done_c));
            check("clear", avg_clear, (c == 1 || c == clr2_c));
            check("res_tready", res_tready, rd ? fir_tready : 1'b0);
            if (c == 0) begin
                check("error_hold", error, last_err);
                check("count_hold", tcount, last_cnt);
            end else begin
                check("error", error, (c >= err_cyc));
                check("trigger_count", tcount, cnt);
            end
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == c) begin
                check("beat_valid", avg_tvalid, 1'b1);
                check("beat_last_data", {avg_tlast, avg_tdata}, exp_q.pop_front());
                void'(exp_cyc_q.pop_front());
            end else begin
                check("beat_idle", avg_tvalid, 1'b0);
            end

            if (hs_now) begin
                hs_seen = 1'b1; done_c = c + 1; end_c = c + 1;
            end else if (TO_EN && rd && c == r + 65535) begin
                end_c = c; clr2_c = c + 1; err_cyc = (err_cyc < c + 1) ? err_cyc : c + 1;
            end
            @(posedge clk); #1;
        end

        check("run_finished", (end_c != BIG), 1'b1);
        check("beats_left", exp_q.size(), 0);
        last_err = (err_cyc != BIG);
        last_cnt = n_trig;
        idle_inputs();
    endtask

    initial begin
        #(10 * 95000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        idle_inputs();
        rst = 1'b1;
        adc_tvalid = 1'b1; fir_tready = 1'b1; res_tvalid = 1'b1; res_tlast = 1'b1; start = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_trigger", trigger, 1'b0);
        check("rst_avg_valid", avg_tvalid, 1'b0);
        check("rst_avg_data", avg_tdata, 32'd0);
        check("rst_avg_last", avg_tlast, 1'b0);
        check("rst_clear", avg_clear, 1'b0);
        check("rst_res_tready", res_tready, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_error", error, 1'b0);
        check("rst_count", tcount, 0);
        check("rst_state", dbg_state, 3'd0);
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // start and abort together while idle: abort wins
        start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("start_abort_trigger", trigger, 1'b0);
            check("start_abort_busy", busy, 1'b0);
            check("start_abort_clear", avg_clear, 1'b0);
            @(posedge clk); #1;
        end

        do_run(0, -1, 0, 1'b0);
        do_run(1, -1, 0, 1'b0);
        do_run(2, -1, 0, 1'b0);
        do_run(0, 1, 3, 1'b0);
        for (int i = 0; i < 4; i++) do_run(3, -1, 0, 1'b0);
        for (int i = 0; i < 3; i++) do_run(3, $urandom_range(0, A - 1), $urandom_range(1, S), 1'b0);
`ifdef ACQ_SEQ_READOUT_TIMEOUT_EN
        do_run(0, -1, 0, 1'b1);
`endif

        // asynchronous reset in the middle of capture: immediate idle, no clear pulse
        start = 1'b1; adc_tvalid = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 1'b0);
        check("async_rst_valid", avg_tvalid, 1'b0);
        check("async_rst_count", tcount, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_clear", avg_clear, 1'b0);
            check("post_rst_busy", busy, 1'b0);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
